sc_config_bank: RTL and testbench
=================================

// Module: sc_config_bank
// PURPOSE
//  Parametrised Avalon-MM configuration/status register bank for the scan converter core.
//  Software writes a staging copy of NUM_CFG 32-bit config registers with byte enables; staging reads back.
//  Staging is copied to the active outputs atomically, only at the next video frame boundary, so
//  mid-frame register updates never tear. Also provides NUM_STATUS read-only status words, a control/status
//  register and registered 1-cycle read latency. Sits between the Nios II bus and the scaler pipeline.
// PARAMETERS
//  NUM_CFG     15       number of config registers (1..64)
//  NUM_STATUS  2        number of read-only status words (1..15)
//  ADDR_W      10       Avalon word-address width
//  CFG_BASE    10'h010  word address of config register 0
//  CTRL_ADDR   10'h00F  word address of control register; elaboration error if it overlaps status/config ranges
// PORTS
//  clk_i                  in   1               system clock
//  rst_i                  in   1               reset, asynchronous, active-high
//  avalon_s_address       in   ADDR_W          word address
//  avalon_s_writedata     in   32              write data
//  avalon_s_byteenable    in   4               byte lanes for writes
//  avalon_s_write         in   1               write strobe
//  avalon_s_read          in   1               read strobe
//  avalon_s_chipselect    in   1               qualifies read/write
//  avalon_s_readdata      out  32              read data, valid with readdatavalid
//  avalon_s_readdatavalid out  1               one-cycle pulse, 1 cycle after accepted read
//  avalon_s_waitrequest_n out  1               constant 1
//  status_i               in   NUM_STATUS*32   status words; word k at [32k+:32], clk_i domain
//  frame_start_i          in   1               frame boundary level/pulse from video domain, async to clk_i
//  cfg_active_o           out  NUM_CFG*32      active config; reg k at [32k+:32]
//  commit_done_o          out  1               one-cycle pulse when active regs are updated
// BEHAVIOUR
//  Reset: staging, active, CTRL, commit counter, readdata all 0; readdatavalid=0; commit_done_o=0.
//  Write (chipselect&write): config addr -> staging byte lanes per byteenable; status addr ignored;
//   unmapped ignored. CTRL write: bit0=1 sets pending (write-1 only; 0 has no effect);
//   bit1 = immediate mode (R/W); other bits ignored.
//  Read (chipselect&read): readdata registered, valid next cycle with readdatavalid=1; else readdata held 0.
//   status addr -> status_i sampled at the accepting cycle; config addr -> staging (not active);
//   CTRL -> {commit_cnt[15:0], 14'b0, immediate, pending}; unmapped -> 0. Back-to-back reads: one per cycle.
//  Frame sync: frame_start_i through 2-FF synchroniser, then rising-edge detect -> 1-cycle frame_evt.
//   Frame_evt latency 3 clk_i cycles after the edge meets setup. Pulses <2 clk_i periods may be lost (documented).
//  Commit: on frame_evt with pending=1 -> active <= staging (all regs in same cycle), pending <= 0,
//   commit_cnt += 1 (16-bit wraps 0xFFFF->0), commit_done_o=1 next cycle. frame_evt with pending=0 -> no-op.
//  Immediate mode=1: every config write also updates that active reg (same byte lanes) 1 cycle later;
//   frame commits still work; commit_cnt increments only on frame commits.
//  Simultaneous events:
//   - config write + commit same cycle: active gets pre-write staging; write lands in staging only; pending stays 0.
//   - CTRL commit write + frame_evt same cycle: commit NOT taken; pending=1, waits for next frame_evt.
//   - Read of CTRL same cycle as commit: returns pre-commit value (pending=1, old cnt).
//  Reset mid-pending: pending cleared, active zeroed; no commit_done_o pulse. Synchroniser flops reset to 0.
// STRUCTURE
//  Package sc_config_pkg: CTRL_PENDING_BIT=0, CTRL_IMMEDIATE_BIT=1, CTRL_CNT_LSB=16, addr-map helper
//   functions is_cfg_addr()/is_status_addr(), typedef cfg_word_t = logic [31:0].
//  Sub-module sc_frame_evt_sync: 2-FF synchroniser + rising-edge detect, async reset; output frame_evt.
//  Top: staging/active arrays via generate loop, CTRL/commit FSM (IDLE / PENDING), registered read mux.
// TESTING
//  1 Reset: assert rst_i mid-traffic -> all cfg_active_o=0, readdatavalid=0, CTRL reads 0x00000000.
//  2 Byteenable: write 0xAABBCCDD to cfg3, be=4'b0101 -> cfg3 staging reads 0x00BB00DD; active still 0.
//  3 Commit: write cfg0=0x12345678, CTRL=0x1 -> CTRL reads 0x1; toggle frame_start_i ->
//     3 cycles later cfg_active_o[31:0]=0x12345678, commit_done_o pulse, CTRL reads 0x00010000.
//  4 Immediate: CTRL=0x2, write cfg1=0xDEADBEEF -> active cfg1=0xDEADBEEF 1 cycle later; commit_cnt unchanged.
//  5 Collisions: CTRL commit write on frame_evt cycle -> no commit; next edge commits. Config write on commit
//     cycle -> active holds old value, staging holds new.
//  6 Reads: back-to-back reads status0, unmapped 0x3FE, cfg_base -> readdatavalid 3 consecutive cycles,
//     data = status_i[31:0], 0, staging0; commit_cnt wrap 0xFFFF->0 after 65536 commits (forced via cnt preload).

Source files
------------

// File: rtl/sc_config_pkg.sv
// Shared definitions for the scan converter config bank: CTRL bit
// positions, the address-map helpers and the lane-merge helper.
package sc_config_pkg;

    localparam int CTRL_PENDING_BIT   = 0;
    localparam int CTRL_IMMEDIATE_BIT = 1;
    localparam int CTRL_CNT_LSB       = 16;

    // Status words occupy word addresses STATUS_BASE .. STATUS_BASE+N-1
    localparam int STATUS_BASE        = 0;

    typedef logic [31:0] cfg_word_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } commit_state_e;

    function automatic logic is_cfg_addr(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int          num
    );
        return (addr >= base) && (addr < base + 32'(num));
    endfunction

    function automatic logic is_status_addr(
        input logic [31:0] addr,
        input int          num
    );
        return addr < 32'(STATUS_BASE) + 32'(num);
    endfunction

    function automatic cfg_word_t merge_lanes(
        input cfg_word_t  old,
        input cfg_word_t  wdata,
        input logic [3:0] be
    );
        cfg_word_t r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return r;
    endfunction

    function automatic cfg_word_t ctrl_word(
        input logic [15:0] cnt,
        input logic        imm,
        input logic        pend
    );
        cfg_word_t w;
        w = '0;
        w[CTRL_CNT_LSB +: 16]     = cnt;
        w[CTRL_IMMEDIATE_BIT]     = imm;
        w[CTRL_PENDING_BIT]       = pend;
        return w;
    endfunction

endpackage

// File: rtl/sc_config_bank_if.sv
// Avalon-MM slave bus bundle for the config bank.
// master drives address/data/strobes; slave returns read data,
// readdatavalid and waitrequest_n.
interface sc_config_bank_if #(
    parameter int ADDR_W = 10
);

    logic [ADDR_W-1:0] address;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic              write;
    logic              read;
    logic              chipselect;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic              waitrequest_n;

    modport master (
        output address,
        output writedata,
        output byteenable,
        output write,
        output read,
        output chipselect,
        input  readdata,
        input  readdatavalid,
        input  waitrequest_n
    );

    modport slave (
        input  address,
        input  writedata,
        input  byteenable,
        input  write,
        input  read,
        input  chipselect,
        output readdata,
        output readdatavalid,
        output waitrequest_n
    );

endinterface

// File: rtl/sc_frame_evt_sync.sv
// Brings the video-domain frame_start level into clk_i and emits a
// one-cycle frame_evt on each rising edge.
// Ports: clk_i, rst_i (async, active-high), frame_start (async in),
//        frame_evt (1-cycle pulse, clk_i domain).
// Pulses narrower than two clk_i periods may be missed.
module sc_frame_evt_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic frame_start,
    output logic frame_evt
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= frame_start;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign frame_evt = sync_q & ~prev_q;

endmodule

// File: rtl/sc_config_bank.sv
// Config/status register bank: staged config registers committed to the
// active outputs atomically on a frame boundary, plus status and CTRL.
// Ports: clk_i, rst_i (async, active-high), avalon_s (Avalon-MM slave),
//        status_i (NUM_STATUS words), frame_start_i (async frame level),
//        cfg_active_o (NUM_CFG active words), commit_done_o (1-cycle pulse).
module sc_config_bank
    import sc_config_pkg::*;
#(
    parameter int               NUM_CFG    = 15,
    parameter int               NUM_STATUS = 2,
    parameter int               ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] CFG_BASE  = 10'h010,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = 10'h00F
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    sc_config_bank_if.slave         avalon_s,
    input  logic [NUM_STATUS*32-1:0] status_i,
    input  logic                    frame_start_i,
    output logic [NUM_CFG*32-1:0]   cfg_active_o,
    output logic                    commit_done_o
);

    localparam logic [31:0] CFG_BASE_W  = 32'(CFG_BASE);
    localparam logic [31:0] CTRL_ADDR_W = 32'(CTRL_ADDR);

    // Address map sanity: CTRL must not alias a status or config word
    if (NUM_CFG < 1 || NUM_CFG > 64) begin : g_bad_num_cfg
        $error("sc_config_bank: NUM_CFG out of range");
    end
    if (NUM_STATUS < 1 || NUM_STATUS > 15) begin : g_bad_num_status
        $error("sc_config_bank: NUM_STATUS out of range");
    end
    if (is_status_addr(CTRL_ADDR_W, NUM_STATUS)) begin : g_ctrl_in_status
        $error("sc_config_bank: CTRL_ADDR overlaps status range");
    end
    if (is_cfg_addr(CTRL_ADDR_W, CFG_BASE_W, NUM_CFG)) begin : g_ctrl_in_cfg
        $error("sc_config_bank: CTRL_ADDR overlaps config range");
    end

    logic [31:0]           addr_w;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ctrl_hit;
    logic                  ctrl_wr;
    logic                  ctrl_set;
    logic                  frame_evt;
    logic                  pending;
    logic                  commit;

    commit_state_e         state_q;
    commit_state_e         state_d;
    logic                  imm_q;
    logic                  imm_d;
    logic [15:0]           cnt_q;
    logic [15:0]           cnt_d;
    logic                  done_q;

    logic [NUM_CFG*32-1:0] stg_flat;
    cfg_word_t             rd_mux;
    cfg_word_t             rdata_q;
    logic                  rvalid_q;

    assign addr_w   = 32'(avalon_s.address);
    assign wr_acc   = avalon_s.chipselect & avalon_s.write;
    assign rd_acc   = avalon_s.chipselect & avalon_s.read;
    assign ctrl_hit = (addr_w == CTRL_ADDR_W);
    assign ctrl_wr  = wr_acc & ctrl_hit;
    assign ctrl_set = ctrl_wr & avalon_s.writedata[CTRL_PENDING_BIT];
    assign pending  = (state_q == ST_PENDING);

    // Only a request already pending before this frame event commits;
    // a CTRL arm landing on the event cycle waits for the next frame.
    assign commit   = pending & frame_evt;

    sc_frame_evt_sync u_frame_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .frame_start (frame_start_i),
        .frame_evt   (frame_evt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            imm_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            imm_q   <= imm_d;
            cnt_q   <= cnt_d;
            done_q  <= commit;
        end
    end

    always_comb begin
        state_d = state_q;
        imm_d   = imm_q;
        cnt_d   = cnt_q;
        if (ctrl_wr) begin
            imm_d = avalon_s.writedata[CTRL_IMMEDIATE_BIT];
        end
        if (commit) begin
            cnt_d = cnt_q + 16'd1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_set) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (commit && !ctrl_set) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
        localparam logic [31:0] ADDR_K = CFG_BASE_W + 32'(k);

        logic      hit;
        cfg_word_t stg_q;
        cfg_word_t act_q;
        cfg_word_t act_d;

        assign hit = wr_acc && (addr_w == ADDR_K);

        // Commit takes the pre-write staging value; an immediate-mode
        // write then overlays its lanes on top of whatever active gets.
        always_comb begin
            act_d = commit ? stg_q : act_q;
            if (hit && imm_q) begin
                act_d = merge_lanes(act_d, avalon_s.writedata,
                                    avalon_s.byteenable);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                stg_q <= '0;
                act_q <= '0;
            end else begin
                if (hit) begin
                    stg_q <= merge_lanes(stg_q, avalon_s.writedata,
                                         avalon_s.byteenable);
                end
                act_q <= act_d;
            end
        end

        assign stg_flat[32*k +: 32]     = stg_q;
        assign cfg_active_o[32*k +: 32] = act_q;
    end

    always_comb begin
        rd_mux = '0;
        if (ctrl_hit) begin
            rd_mux = ctrl_word(cnt_q, imm_q, pending);
        end else if (is_cfg_addr(addr_w, CFG_BASE_W, NUM_CFG)) begin
            for (int k = 0; k < NUM_CFG; k++) begin
                if (addr_w == CFG_BASE_W + 32'(k)) begin
                    rd_mux = stg_flat[32*k +: 32];
                end
            end
        end else if (is_status_addr(addr_w, NUM_STATUS)) begin
            for (int k = 0; k < NUM_STATUS; k++) begin
                if (addr_w == 32'(STATUS_BASE + k)) begin
                    rd_mux = status_i[32*k +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            rdata_q  <= rd_acc ? rd_mux : '0;
        end
    end

    assign avalon_s.readdata      = rdata_q;
    assign avalon_s.readdatavalid = rvalid_q;
    assign avalon_s.waitrequest_n = 1'b1;
    assign commit_done_o          = done_q;

endmodule

// File: tb/tb_sc_config_bank.sv
// Self-checking bench for sc_config_bank: register-level model compared
// every cycle, plus directed literal checks of the documented scenarios.
module tb_sc_config_bank;

    localparam int NUM_CFG    = 15;
    localparam int NUM_STATUS = 2;
    localparam int ADDR_W     = 10;
    localparam int CFG_BASE   = 16;
    localparam int CTRL_A     = 15;
    localparam logic [9:0] CTRL = 10'h00F;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    frame = 1'b0;
    logic [NUM_STATUS*32-1:0] status = '0;
    logic [NUM_CFG*32-1:0]   act;
    logic                    done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_config_bank_if #(.ADDR_W(ADDR_W)) bus ();

    sc_config_bank #(
        .NUM_CFG    (NUM_CFG),
        .NUM_STATUS (NUM_STATUS),
        .ADDR_W     (ADDR_W),
        .CFG_BASE   (10'h010),
        .CTRL_ADDR  (10'h00F)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .avalon_s      (bus),
        .status_i      (status),
        .frame_start_i (frame),
        .cfg_active_o  (act),
        .commit_done_o (done)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_stg [NUM_CFG];
    logic [31:0] m_act [NUM_CFG];
    logic        m_pend;
    logic        m_imm;
    logic [15:0] m_cnt;
    logic [31:0] e_rd;
    logic        e_rv;
    logic        e_done;
    logic [2:0]  fs_hist;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == CTRL_A) return {m_cnt, 14'b0, m_imm, m_pend};
        if (a >= CFG_BASE && a < CFG_BASE + NUM_CFG) return m_stg[a - CFG_BASE];
        if (a >= 0 && a < NUM_STATUS) return status[32*a +: 32];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CFG; i++) begin
            m_stg[i] = '0;
            m_act[i] = '0;
        end
        m_pend  = 1'b0;
        m_imm   = 1'b0;
        m_cnt   = '0;
        e_rd    = '0;
        e_rv    = 1'b0;
        e_done  = 1'b0;
        fs_hist = '0;
    endtask

    task automatic model_step();
        int          a;
        logic        evt;
        logic        cw;
        logic        cset;
        logic [31:0] wd;
        logic [3:0]  be;
        a    = int'(bus.address);
        wd   = bus.writedata;
        be   = bus.byteenable;
        // frame_start seen high two samples back, low three back
        evt  = fs_hist[1] && !fs_hist[2];
        fs_hist = {fs_hist[1:0], frame};
        e_rv = bus.chipselect && bus.read;
        e_rd = e_rv ? m_read(a) : 32'h0;
        e_done = m_pend && evt;
        if (e_done) begin
            for (int i = 0; i < NUM_CFG; i++) m_act[i] = m_stg[i];
            m_cnt = m_cnt + 16'd1;
        end
        cw   = bus.chipselect && bus.write;
        cset = 1'b0;
        if (cw && a >= CFG_BASE && a < CFG_BASE + NUM_CFG) begin
            m_stg[a - CFG_BASE] = merge(m_stg[a - CFG_BASE], wd, be);
            if (m_imm) m_act[a - CFG_BASE] = merge(m_act[a - CFG_BASE], wd, be);
        end
        if (cw && a == CTRL_A) begin
            m_imm = wd[1];
            cset  = wd[0];
        end
        if (cset) m_pend = 1'b1;
        else if (e_done) m_pend = 1'b0;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else model_step();
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            for (int k = 0; k < NUM_CFG; k++) begin
                chk($sformatf("mdl_act%0d", k), act[32*k +: 32], m_act[k]);
            end
            chk("mdl_rvalid", 32'(bus.readdatavalid), 32'(e_rv));
            chk("mdl_rdata", bus.readdata, e_rd);
            chk("mdl_done", 32'(done), 32'(e_done));
            chk("mdl_waitreq_n", 32'(bus.waitrequest_n), 32'd1);
        end
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic idle();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        bus.byteenable = '0;
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.read       = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = be;
        step();
        idle();
    endtask

    task automatic drv_rd(input logic [9:0] a);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.write      = 1'b0;
        bus.address    = a;
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] exp,
                      input string nm);
        drv_rd(a);
        step();
        idle();
        chk({nm, "_valid"}, 32'(bus.readdatavalid), 32'd1);
        chk(nm, bus.readdata, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle();
        step(3);
        rst = 1'b0;

        // reset state
        chk("rst_act_zero", 32'(act != '0), 32'd0);
        chk("rst_rvalid", 32'(bus.readdatavalid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rd(CTRL, 32'h0000_0000, "rst_ctrl");

        // byte enables
        wr(10'h013, 32'hAABBCCDD, 4'b0101);
        rd(10'h013, 32'h00BB00DD, "be_stg3");
        chk("be_act3", act[3*32 +: 32], 32'h0);

        // frame commit
        wr(10'h010, 32'h12345678, 4'hF);
        wr(CTRL, 32'h1, 4'hF);
        rd(CTRL, 32'h0000_0001, "ctrl_pend");
        frame = 1'b1;
        step(2);
        chk("pre_commit_act0", act[31:0], 32'h0);
        step();
        chk("commit_act0", act[31:0], 32'h12345678);
        chk("commit_act3", act[3*32 +: 32], 32'h00BB00DD);
        chk("commit_done", 32'(done), 32'd1);
        step();
        chk("done_one_cycle", 32'(done), 32'd0);
        frame = 1'b0;
        step(3);
        rd(CTRL, 32'h0001_0000, "ctrl_cnt1");

        // immediate mode
        wr(CTRL, 32'h2, 4'hF);
        wr(10'h011, 32'hDEADBEEF, 4'hF);
        chk("imm_act1", act[1*32 +: 32], 32'hDEADBEEF);
        rd(CTRL, 32'h0001_0002, "imm_ctrl");

        // CTRL arm on the frame event cycle
        wr(CTRL, 32'h0, 4'hF);
        wr(10'h012, 32'h22222222, 4'hF);
        chk("staged_act2", act[2*32 +: 32], 32'h0);
        frame = 1'b1;
        step(2);
        wr(CTRL, 32'h1, 4'hF);
        chk("coll_no_done", 32'(done), 32'd0);
        chk("coll_act2", act[2*32 +: 32], 32'h0);
        frame = 1'b0;
        step(3);
        rd(CTRL, 32'h0001_0001, "coll_pend");
        frame = 1'b1;
        step(3);
        chk("late_act2", act[2*32 +: 32], 32'h22222222);
        chk("late_done", 32'(done), 32'd1);
        frame = 1'b0;
        step(3);
        rd(CTRL, 32'h0002_0000, "ctrl_cnt2");

        // config write on the commit cycle
        wr(10'h014, 32'h44444444, 4'hF);
        wr(CTRL, 32'h1, 4'hF);
        frame = 1'b1;
        step(2);
        wr(10'h014, 32'h55555555, 4'hF);
        chk("cw_act4", act[4*32 +: 32], 32'h44444444);
        chk("cw_done", 32'(done), 32'd1);
        frame = 1'b0;
        rd(10'h014, 32'h55555555, "cw_stg4");
        rd(CTRL, 32'h0003_0000, "cw_ctrl");
        step(3);

        // back-to-back reads: status, unmapped, config
        status = {32'hCAFE0001, 32'h5A5A1234};
        wr(10'h000, 32'hFFFFFFFF, 4'hF);
        drv_rd(10'h000);
        step();
        chk("b2b_v0", 32'(bus.readdatavalid), 32'd1);
        chk("b2b_status0", bus.readdata, 32'h5A5A1234);
        drv_rd(10'h3FE);
        step();
        chk("b2b_v1", 32'(bus.readdatavalid), 32'd1);
        chk("b2b_unmapped", bus.readdata, 32'h0);
        drv_rd(10'h010);
        step();
        idle();
        chk("b2b_v2", 32'(bus.readdatavalid), 32'd1);
        chk("b2b_cfg0", bus.readdata, 32'h12345678);
        step();
        chk("b2b_idle_v", 32'(bus.readdatavalid), 32'd0);
        chk("b2b_idle_d", bus.readdata, 32'h0);
        rd(10'h001, 32'hCAFE0001, "status1");

        // commit counter wrap
        force dut.cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step();
        release dut.cnt_q;
        rd(CTRL, 32'hFFFF_0000, "cnt_preload");
        wr(CTRL, 32'h1, 4'hF);
        frame = 1'b1;
        step(3);
        chk("wrap_done", 32'(done), 32'd1);
        frame = 1'b0;
        step(3);
        rd(CTRL, 32'h0000_0000, "cnt_wrap");

        // reset while a commit is pending and a read is in flight
        wr(10'h015, 32'h55AA55AA, 4'hF);
        wr(CTRL, 32'h1, 4'hF);
        drv_rd(CTRL);
        #2 rst = 1'b1;
        step();
        chk("rst2_act_zero", 32'(act != '0), 32'd0);
        chk("rst2_rvalid", 32'(bus.readdatavalid), 32'd0);
        chk("rst2_done", 32'(done), 32'd0);
        rst = 1'b0;
        idle();
        rd(CTRL, 32'h0000_0000, "rst2_ctrl");
        rd(10'h015, 32'h0, "rst2_stg5");
        frame = 1'b1;
        step(3);
        chk("rst2_no_commit", 32'(done), 32'd0);
        chk("rst2_act5", act[5*32 +: 32], 32'h0);
        frame = 1'b0;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
